rx_edge_bit_sampler: RTL and testbench
======================================

Name: rx_edge_bit_sampler

Overview:
Oversampling timing and data-recovery stage of the UART receiver. It sits directly upstream of the RX control FSM and produces the `edge_cnt` and `bit_cnt` values that the FSM sequences on. It also recovers each serial bit from `RX_IN` by 3-sample majority vote and presents it as `sampled_bit` for the parity, start, stop and deserializer checkers. It is enabled and gated only by the FSM's `enable` and `data_samp_en` outputs.

Parameters:
- PRESCALE_W, 6, width of the `Prescale` and `edge_cnt` buses.
- BIT_CNT_W, 4, width of `bit_cnt`.

Ports:
- CLK  input  1  receiver oversampling clock.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line, already synchronized to CLK; idle = 1.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
- enable  input  1  counter enable from the FSM.
- data_samp_en  input  1  sampling enable from the FSM.
- edge_cnt  output  PRESCALE_W  oversample edge position within the current bit.
- bit_cnt  output  BIT_CNT_W  number of completed bit periods in the frame.
- sampled_bit  output  1  majority-voted value of the current bit.
- sample_done  output  1  one-cycle pulse when `sampled_bit` has just been updated.

Behaviour:
- Reset: when RST=1 at a CLK edge, the following are cleared: `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, `sample_done`=0, the sample shift register=3'b111, and `presc_q`=16. Reset takes priority over everything, including in the middle of a frame.
- Prescale capture: `presc_q` loads `Prescale` on every cycle with `enable`=0 and holds while `enable`=1. A change to `Prescale` during a frame therefore has no effect until the next frame.
- Counters, when `enable`=0: `edge_cnt`<=0 and `bit_cnt`<=0 on the next cycle. This is the inter-frame clear.
- Counters, when `enable`=1 and `edge_cnt` != `presc_q`: `edge_cnt`<=`edge_cnt`+1.
- Counters, when `enable`=1 and `edge_cnt` == `presc_q`: `edge_cnt`<=1 and `bit_cnt`<=`bit_cnt`+1.
- Resulting bit timing: the first bit period runs 0..presc_q, which is presc_q+1 cycles and absorbs the FSM's IDLE detection cycle. Every later bit runs 1..presc_q, which is presc_q cycles.
- The value `edge_cnt` == `presc_q` is always reached and held for exactly one cycle, because the FSM's stop-bit check depends on it.
- `bit_cnt` saturates at 15 and does not wrap.
- Sampling points: mid = presc_q>>1. When `data_samp_en`=1, `RX_IN` is shifted into a 3-bit register at `edge_cnt` = mid-1, mid and mid+1.
- Vote: in the cycle where `edge_cnt` == mid+1 (with `data_samp_en`=1), the registered result is computed as the majority of {s[1], s[0], RX_IN}. That is, the third sample is taken combinationally in that same cycle.
- Output timing: `sampled_bit` updates on the clock edge ending that cycle. `sample_done`=1 for exactly the following cycle, which is `edge_cnt` == mid+2. This matches the FSM's deserializer strobe.
- Holding: `sampled_bit` holds its value between votes.
- Sampling disabled: with `data_samp_en`=0, the shift register is not written, no vote occurs and `sample_done` stays 0. The counters keep running if `enable`=1.
- Simultaneous events: if `enable` falls in the same cycle as a sample point, the counter clear takes precedence on the next edge and no `sample_done` is issued for the interrupted bit.
- Back-to-back frames: the FSM drops `enable` for one cycle at stop completion. The counters return to 0 and the next frame proceeds identically to the first.
- Latency: `RX_IN` to `sampled_bit` is 1 cycle after the mid+1 sample point.

Optional Feature:
- Macro: RX_SAMPLE_NOISE_FLAG_EN.
- When defined: adds an output port `sample_noise` (1 bit). It is registered alongside `sampled_bit` and is set when the three votes disagree (i.e. they are not all 0 and not all 1). It is valid on the same cycle as `sample_done`, held otherwise, and reset to 0.
- When undefined: the port and its logic are absent. The voting result is identical either way.

Test Plan:
- Prescale=16, enable held 1 for 40 cycles, data_samp_en=0 -> `edge_cnt` runs 0..16, then 1..16, then 1..7. `bit_cnt` steps to 1 at cycle 17 and to 2 at cycle 33. `sample_done` never asserts.
- Prescale=8, a frame of 0x5A with no parity and data_samp_en=1 -> `sample_done` pulses at `edge_cnt`=6 in every bit. The `sampled_bit` sequence is 0 (start), then 0,1,0,1,1,0,1,0 (LSB first), then 1 (stop).
- Prescale=16, RX_IN glitched to 1 only at `edge_cnt`=8 of a 0 bit -> `sampled_bit`=0. With RX_SAMPLE_NOISE_FLAG_EN defined, `sample_noise`=1 for that bit.
- Prescale changed from 16 to 32 at `bit_cnt`=3 mid-frame -> wrap stays at 16 until `enable`=0. The next frame wraps at 32, with samples at 15, 16 and 17.
- enable held 1 for 300 cycles at Prescale=8 -> `bit_cnt` saturates at 15 and `edge_cnt` keeps wrapping 1..8.
- RST=1 asserted at `edge_cnt`=5, `bit_cnt`=4 -> next cycle `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1 and `sample_done`=0, even with `enable`=1 held.

Source files
------------

// File: rtl/rx_edge_bit_sampler.sv
// UART RX oversampling stage: edge/bit counters plus 3-sample majority-vote bit recovery.
// Optional: define RX_SAMPLE_NOISE_FLAG_EN to add the registered sample_noise output.
module rx_edge_bit_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  enable,
  input  logic                  data_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_done
`ifdef RX_SAMPLE_NOISE_FLAG_EN
  ,
  output logic                  sample_noise
`endif
);

  localparam logic [PRESCALE_W-1:0] PRESC_RST = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_presc_q;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [2:0]            r_samples;
  logic                  r_sampled_bit;
  logic                  r_sample_done;

  logic [PRESCALE_W-1:0] w_mid;
  logic                  w_wrap;
  logic                  w_bit_sat;
  logic                  w_samp_pt;
  logic                  w_vote_pt;
  logic                  w_majority;
  logic                  w_noise;

  always_comb begin
    w_mid     = r_presc_q >> 1;
    w_wrap    = (r_edge_cnt == r_presc_q);
    w_bit_sat = (r_bit_cnt == '1);
    // Sampling is gated by enable so a frame aborted at a sample point yields no strobe.
    w_samp_pt = enable && data_samp_en &&
                ((r_edge_cnt == w_mid - ONE) || (r_edge_cnt == w_mid) ||
                 (r_edge_cnt == w_mid + ONE));
    w_vote_pt = enable && data_samp_en && (r_edge_cnt == w_mid + ONE);
    // NOTE: the third vote is the live RX_IN, not a register, so the result lands one edge after mid+1.
    w_majority = (r_samples[1] & r_samples[0]) | (r_samples[1] & RX_IN) |
                 (r_samples[0] & RX_IN);
    w_noise    = (r_samples[1] | r_samples[0] | RX_IN) &
                 ~(r_samples[1] & r_samples[0] & RX_IN);
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc_q  <= PRESC_RST;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!enable) begin
      r_presc_q  <= Prescale;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_wrap) begin
      r_edge_cnt <= ONE;
      if (!w_bit_sat) r_bit_cnt <= r_bit_cnt + 1'b1;
    end else begin
      r_edge_cnt <= r_edge_cnt + ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_samples     <= 3'b111;
      r_sampled_bit <= 1'b1;
      r_sample_done <= 1'b0;
    end else begin
      r_sample_done <= w_vote_pt;
      if (w_samp_pt) r_samples <= {r_samples[1:0], RX_IN};
      if (w_vote_pt) r_sampled_bit <= w_majority;
    end
  end

`ifdef RX_SAMPLE_NOISE_FLAG_EN
  logic r_sample_noise;

  always_ff @(posedge CLK) begin
    if (RST)            r_sample_noise <= 1'b0;
    else if (w_vote_pt) r_sample_noise <= w_noise;
  end

  assign sample_noise = r_sample_noise;
`else
  logic w_noise_unused;
  assign w_noise_unused = w_noise;
`endif

  assign edge_cnt    = r_edge_cnt;
  assign bit_cnt     = r_bit_cnt;
  assign sampled_bit = r_sampled_bit;
  assign sample_done = r_sample_done;

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Directed self-checking bench for rx_edge_bit_sampler; outputs are sampled on the falling edge.
module tb_rx_edge_bit_sampler;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = PW'(16);
  logic          enable = 1'b0;
  logic          data_samp_en = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sampled_bit;
  logic          sample_done;
`ifdef RX_SAMPLE_NOISE_FLAG_EN
  logic          sample_noise;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  rx_edge_bit_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .enable(enable), .data_samp_en(data_samp_en),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sampled_bit(sampled_bit), .sample_done(sample_done)
`ifdef RX_SAMPLE_NOISE_FLAG_EN
    , .sample_noise(sample_noise)
`endif
  );

  task automatic idle(input int n);
    enable = 1'b0; data_samp_en = 1'b0; RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++; if (edge_cnt !== PW'(0)) begin n_err++; $display("FAIL reset_edge_cnt got %0d want 0", edge_cnt); end
    n_cmp++; if (bit_cnt !== BW'(0)) begin n_err++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
    n_cmp++; if (sampled_bit !== 1'b1) begin n_err++; $display("FAIL reset_sampled_bit got %b want 1", sampled_bit); end
    n_cmp++; if (sample_done !== 1'b0) begin n_err++; $display("FAIL reset_sample_done got %b want 0", sample_done); end
`ifdef RX_SAMPLE_NOISE_FLAG_EN
    n_cmp++; if (sample_noise !== 1'b0) begin n_err++; $display("FAIL reset_sample_noise got %b want 0", sample_noise); end
`endif
    RST = 1'b0;
  endtask

  task automatic test_counters();
    Prescale = PW'(16);
    idle(2);
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      int exp_e, exp_b;
      exp_e = (c <= 16) ? c : ((c - 17) % 16) + 1;
      exp_b = (c < 17) ? 0 : 1 + (c - 17) / 16;
      n_cmp++; if (edge_cnt !== PW'(exp_e)) begin n_err++; $display("FAIL cnt_edge c=%0d got %0d want %0d", c, edge_cnt, exp_e); end
      n_cmp++; if (bit_cnt !== BW'(exp_b)) begin n_err++; $display("FAIL cnt_bit c=%0d got %0d want %0d", c, bit_cnt, exp_b); end
      n_cmp++; if (sample_done !== 1'b0) begin n_err++; $display("FAIL cnt_no_done c=%0d got %b want 0", c, sample_done); end
      @(negedge CLK);
    end
    idle(1);
  endtask

  task automatic test_frame_5a();
    logic [9:0] fr;
    fr = {1'b1, 8'h5A, 1'b0};
    Prescale = PW'(8);
    idle(2);
    enable = 1'b1; data_samp_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      int k;
      logic exp_done;
      k = (c < 9) ? 0 : 1 + (c - 9) / 8;
      RX_IN = fr[k];
      exp_done = ((c % 8) == 6);
      n_cmp++; if (sample_done !== exp_done) begin n_err++; $display("FAIL frame_done c=%0d got %b want %b", c, sample_done, exp_done); end
      if (exp_done) begin
        n_cmp++; if (sampled_bit !== fr[c / 8]) begin n_err++; $display("FAIL frame_bit%0d got %b want %b", c / 8, sampled_bit, fr[c / 8]); end
        n_cmp++; if (edge_cnt !== PW'(6)) begin n_err++; $display("FAIL frame_done_edge c=%0d got %0d want 6", c, edge_cnt); end
      end
      @(negedge CLK);
    end
    idle(1);
  endtask

  task automatic test_glitch();
    logic [3:0] base;
    base = 4'b0110;
    Prescale = PW'(16);
    idle(2);
    enable = 1'b1; data_samp_en = 1'b1;
    for (int c = 0; c < 64; c++) begin
      int k, e;
      logic rx;
      k = (c < 17) ? 0 : 1 + (c - 17) / 16;
      e = (c < 17) ? c : ((c - 17) % 16) + 1;
      rx = base[k];
      if ((k == 0 && e == 8) || (k == 2 && e == 9) || (k == 3 && e == 7)) rx = ~rx;
      RX_IN = rx;
      n_cmp++; if (sample_done !== (e == 10)) begin n_err++; $display("FAIL glitch_done c=%0d got %b want %b", c, sample_done, (e == 10)); end
      if (e == 10) begin
        n_cmp++; if (sampled_bit !== base[k]) begin n_err++; $display("FAIL glitch_bit%0d got %b want %b", k, sampled_bit, base[k]); end
`ifdef RX_SAMPLE_NOISE_FLAG_EN
        n_cmp++; if (sample_noise !== (k != 1)) begin n_err++; $display("FAIL glitch_noise%0d got %b want %b", k, sample_noise, (k != 1)); end
`endif
      end
      @(negedge CLK);
    end
    idle(1);
  endtask

  task automatic test_prescale_change();
    Prescale = PW'(16);
    idle(2);
    enable = 1'b1; data_samp_en = 1'b1; RX_IN = 1'b1;
    for (int c = 0; c < 66; c++) begin
      if (c == 49) begin
        n_cmp++; if (bit_cnt !== BW'(3)) begin n_err++; $display("FAIL pchg_bit3 got %0d want 3", bit_cnt); end
        Prescale = PW'(32);
      end
      if (c == 64) begin
        n_cmp++; if (edge_cnt !== PW'(16)) begin n_err++; $display("FAIL pchg_hold_wrap got %0d want 16", edge_cnt); end
      end
      if (c == 65) begin
        n_cmp++; if (edge_cnt !== PW'(1)) begin n_err++; $display("FAIL pchg_wrap_edge got %0d want 1", edge_cnt); end
        n_cmp++; if (bit_cnt !== BW'(4)) begin n_err++; $display("FAIL pchg_wrap_bit got %0d want 4", bit_cnt); end
      end
      @(negedge CLK);
    end
    idle(1);
    enable = 1'b1; data_samp_en = 1'b1;
    for (int c = 0; c < 34; c++) begin
      int e;
      e = (c < 33) ? c : ((c - 33) % 32) + 1;
      RX_IN = (e >= 15 && e <= 17) ? 1'b0 : 1'b1;
      n_cmp++; if (sample_done !== (c == 18)) begin n_err++; $display("FAIL p32_done c=%0d got %b want %b", c, sample_done, (c == 18)); end
      if (c == 0) begin
        n_cmp++; if (edge_cnt !== PW'(0)) begin n_err++; $display("FAIL b2b_edge_start got %0d want 0", edge_cnt); end
      end
      if (c == 18) begin
        n_cmp++; if (sampled_bit !== 1'b0) begin n_err++; $display("FAIL p32_sampled got %b want 0", sampled_bit); end
      end
      if (c == 32) begin
        n_cmp++; if (edge_cnt !== PW'(32)) begin n_err++; $display("FAIL p32_top got %0d want 32", edge_cnt); end
      end
      if (c == 33) begin
        n_cmp++; if (edge_cnt !== PW'(1)) begin n_err++; $display("FAIL p32_wrap_edge got %0d want 1", edge_cnt); end
        n_cmp++; if (bit_cnt !== BW'(1)) begin n_err++; $display("FAIL p32_wrap_bit got %0d want 1", bit_cnt); end
      end
      @(negedge CLK);
    end
    idle(1);
  endtask

  task automatic test_saturation();
    Prescale = PW'(8);
    idle(2);
    enable = 1'b1;
    for (int c = 0; c < 300; c++) begin
      int exp_e, exp_b;
      exp_e = (c < 9) ? c : ((c - 9) % 8) + 1;
      exp_b = (c < 9) ? 0 : 1 + (c - 9) / 8;
      if (exp_b > 15) exp_b = 15;
      n_cmp++; if (edge_cnt !== PW'(exp_e)) begin n_err++; $display("FAIL sat_edge c=%0d got %0d want %0d", c, edge_cnt, exp_e); end
      n_cmp++; if (bit_cnt !== BW'(exp_b)) begin n_err++; $display("FAIL sat_bit c=%0d got %0d want %0d", c, bit_cnt, exp_b); end
      @(negedge CLK);
    end
    idle(1);
  endtask

  task automatic test_rst_midframe();
    Prescale = PW'(8);
    idle(2);
    enable = 1'b1; data_samp_en = 1'b1; RX_IN = 1'b0;
    repeat (37) @(negedge CLK);
    n_cmp++; if (edge_cnt !== PW'(5) || bit_cnt !== BW'(4)) begin n_err++; $display("FAIL rst_pre got e=%0d b=%0d want e=5 b=4", edge_cnt, bit_cnt); end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++; if (edge_cnt !== PW'(0)) begin n_err++; $display("FAIL rst_mid_edge got %0d want 0", edge_cnt); end
    n_cmp++; if (bit_cnt !== BW'(0)) begin n_err++; $display("FAIL rst_mid_bit got %0d want 0", bit_cnt); end
    n_cmp++; if (sampled_bit !== 1'b1) begin n_err++; $display("FAIL rst_mid_sampled got %b want 1", sampled_bit); end
    n_cmp++; if (sample_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b want 0", sample_done); end
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    n_cmp++; if (edge_cnt !== PW'(12) || bit_cnt !== BW'(0)) begin n_err++; $display("FAIL rst_presc16 got e=%0d b=%0d want e=12 b=0", edge_cnt, bit_cnt); end
    idle(1);
  endtask

  task automatic test_enable_at_vote();
    RST = 1'b1; Prescale = PW'(8);
    idle(1);
    RST = 1'b0;
    @(negedge CLK);
    enable = 1'b1; data_samp_en = 1'b1; RX_IN = 1'b0;
    repeat (5) @(negedge CLK);
    n_cmp++; if (edge_cnt !== PW'(5)) begin n_err++; $display("FAIL ena_vote_pre got %0d want 5", edge_cnt); end
    enable = 1'b0;
    @(negedge CLK);
    n_cmp++; if (sample_done !== 1'b0) begin n_err++; $display("FAIL ena_vote_done got %b want 0", sample_done); end
    n_cmp++; if (edge_cnt !== PW'(0)) begin n_err++; $display("FAIL ena_vote_edge got %0d want 0", edge_cnt); end
    n_cmp++; if (sampled_bit !== 1'b1) begin n_err++; $display("FAIL ena_vote_sampled got %b want 1", sampled_bit); end
    idle(1);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_counters();
    test_frame_5a();
    test_glitch();
    test_prescale_change();
    test_saturation();
    test_rst_midframe();
    test_enable_at_vote();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
